uart_rx_ctrl: RTL and testbench

//  Sequences the UART receiver and turns its byte output into a packet stream.

---
 rtl/uart_rx_ctrl_pkg.sv | 25 ++
 rtl/uart_rx_ctrl_fifo.sv | 66 ++++++
 rtl/uart_rx_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and timing defaults for the UART receive controller.
package uart_rx_ctrl_pkg;

  localparam int unsigned CLK_FREQ_DEF = 32'd50_000_000;
  localparam int unsigned BAUD_DEF     = 32'd115_200;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_ARM   = 3'd1,
    ST_RECV  = 3'd2,
    ST_STORE = 3'd3,
    ST_FLUSH = 3'd4
  } rx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } rx_entry_t;

  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_s;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push_s = push_i & (~full_s | do_pop_s);

  assign valid_o    = ~empty_s;
  assign data_o     = empty_s ? {WIDTH{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = push_i & ~do_push_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver sequencer: arms the UART receiver, stages good bytes and
// frames them into packets closed by an idle gap or by a disable.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = CLK_FREQ_DEF,
  parameter int unsigned BAUD      = BAUD_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IDLE_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clr,
  output logic       rxEn,
  input  logic [7:0] rx_data,
  input  logic       rxBusy,
  input  logic       rxDone,
  input  logic       right,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  localparam int unsigned BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned IDLE_CYC = IDLE_BITS * BIT_CYC;
  localparam int unsigned TW       = $clog2(IDLE_CYC + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  rx_state_e     state_q, state_d;
  logic          rx_en_q, rx_en_d;
  logic [7:0]    cap_data_q;
  logic          cap_ok_q;
  logic          stg_v_q, stg_v_d;
  logic [7:0]    stg_data_q, stg_data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    err_q, err_d;

  logic          push_s, fifo_ovf_s, fifo_valid_s;
  rx_entry_t     push_entry_s, head_s;
  logic          store_good_s, store_bad_s, idle_hit_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (enable) state_d = ST_ARM; else state_d = ST_OFF;
      // A frame already under way wins over a disable so no byte is cut short.
      ST_ARM:   if (rxBusy) state_d = ST_RECV;
                else if (!enable) state_d = ST_FLUSH;
                else state_d = ST_ARM;
      ST_RECV:  if (rxDone) state_d = ST_STORE; else state_d = ST_RECV;
      ST_STORE: if (enable) state_d = ST_ARM; else state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_OFF;
      default:  state_d = ST_OFF;
    endcase
    rx_en_d = (state_d == ST_ARM) || (state_d == ST_RECV) || (state_d == ST_STORE);
  end

  assign store_good_s = (state_q == ST_STORE) &&  cap_ok_q;
  assign store_bad_s  = (state_q == ST_STORE) && !cap_ok_q;
  assign idle_hit_s   = stg_v_q && !rxBusy && (timer_q == IDLE_LAST);

  always_comb begin
    push_s       = 1'b0;
    push_entry_s = '{last: 1'b0, data: 8'h00};
    stg_v_d      = stg_v_q;
    stg_data_d   = stg_data_q;
    timer_d      = timer_q;
    if (store_good_s) begin
      // The previous staged byte is known not to end its packet.
      push_s       = stg_v_q;
      push_entry_s = '{last: 1'b0, data: stg_data_q};
      stg_v_d      = 1'b1;
      stg_data_d   = cap_data_q;
      timer_d      = {TW{1'b0}};
    end else if ((state_q == ST_FLUSH) || idle_hit_s) begin
      push_s       = stg_v_q;
      push_entry_s = '{last: 1'b1, data: stg_data_q};
      stg_v_d      = 1'b0;
      timer_d      = {TW{1'b0}};
    end else if (rxBusy || !stg_v_q) begin
      timer_d      = {TW{1'b0}};
    end else begin
      timer_d      = timer_q + TMR_ONE;
    end
  end

  always_comb begin
    err_d = err_q;
    ovf_d = ovf_q;
    if (clr) begin
      err_d = store_bad_s ? 8'd1 : 8'd0;
    end else if (store_bad_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
    if (fifo_ovf_s) begin
      ovf_d = 1'b1;
    end else if (clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      rx_en_q    <= 1'b0;
      cap_data_q <= 8'h00;
      cap_ok_q   <= 1'b0;
      stg_v_q    <= 1'b0;
      stg_data_q <= 8'h00;
      timer_q    <= {TW{1'b0}};
      ovf_q      <= 1'b0;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      rx_en_q    <= rx_en_d;
      if ((state_q == ST_RECV) && rxDone) begin
        cap_data_q <= rx_data;
        cap_ok_q   <= right;
      end
      stg_v_q    <= stg_v_d;
      stg_data_q <= stg_data_d;
      timer_q    <= timer_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (9),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_s),
    .data_i     (push_entry_s),
    .pop_i      (m_ready),
    .data_o     (head_s),
    .valid_o    (fifo_valid_s),
    .overflow_o (fifo_ovf_s)
  );

  assign rxEn    = rx_en_q;
  assign m_valid = fifo_valid_s;
  assign m_data  = head_s.data;
  assign m_last  = head_s.last;
  assign ovf     = ovf_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed plus randomized bench for uart_rx_ctrl with a packet-level reference model.
module tb_uart_rx_ctrl;

  localparam int BIT_CYC  = 434;
  localparam int IDLE_CYC = 20 * BIT_CYC;
  localparam int DEPTH    = 16;

  logic       clk = 1'b0;
  logic       rst_n, enable, clr, rxEn, rxBusy, rxDone, right;
  logic       m_valid, m_last, m_ready, ovf;
  logic [7:0] rx_data, m_data, err_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected FIFO contents, the pending byte, counters.
  logic [8:0] exp_q[$];
  bit         pend_v;
  logic [7:0] pend_d;
  int         err_m;
  bit         ovf_m;

  always #10 clk = ~clk;

  uart_rx_ctrl #(
    .CLK_FREQ (50_000_000), .BAUD (115200), .DEPTH (DEPTH), .IDLE_BITS (20)
  ) dut (
    .clk (clk), .rst_n (rst_n), .enable (enable), .clr (clr), .rxEn (rxEn),
    .rx_data (rx_data), .rxBusy (rxBusy), .rxDone (rxDone), .right (right),
    .m_valid (m_valid), .m_data (m_data), .m_last (m_last), .m_ready (m_ready),
    .ovf (ovf), .err_cnt (err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_push(input bit last, input logic [7:0] d);
    if (exp_q.size() >= DEPTH) ovf_m = 1'b1;
    else exp_q.push_back({last, d});
  endtask

  task automatic model_good(input logic [7:0] d);
    if (pend_v) model_push(1'b0, pend_d);
    pend_v = 1'b1;
    pend_d = d;
  endtask

  task automatic model_gap(input int n);
    if (pend_v && n > IDLE_CYC) begin
      model_push(1'b1, pend_d);
      pend_v = 1'b0;
    end
  endtask

  task automatic model_flush();
    if (pend_v) model_push(1'b1, pend_d);
    pend_v = 1'b0;
  endtask

  task automatic frame(input logic [7:0] b, input bit ok, input int busy);
    rxBusy = 1'b1;
    tick(busy);
    rxBusy = 1'b0; rx_data = b; right = ok; rxDone = 1'b1;
    tick(1);
    rxDone = 1'b0;
    if (ok) model_good(b);
    else if (err_m < 255) err_m++;
  endtask

  task automatic idle(input int n);
    tick(n);
    model_gap(n);
  endtask

  task automatic drain(input bit rand_ready, output int popped);
    logic [8:0] e;
    int n;
    n = 0;
    popped = 0;
    while (exp_q.size() != 0 && n < 400) begin
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        chk("drain_data", {24'd0, m_data}, {23'd0, e[7:0]});
        chk("drain_last", {31'd0, m_last}, {31'd0, e[8]});
        popped++;
      end
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_empty", {31'd0, m_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int popped;
    bit big_used;
    int gap;
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; rx_data = 8'h00;
    rxBusy = 1'b0; rxDone = 1'b0; right = 1'b0; m_ready = 1'b0;
    pend_v = 1'b0; pend_d = 8'h00; err_m = 0; ovf_m = 1'b0;

    // Reset values
    tick(3);
    chk("rst_rxEn", {31'd0, rxEn}, 0);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_m_last", {31'd0, m_last}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    rst_n = 1'b1;
    tick(2);

    // 1: single byte, packet closed exactly IDLE_CYC cycles after the load
    enable = 1'b1;
    tick(2);
    chk("t1_rxEn", {31'd0, rxEn}, 1);
    frame(8'hB5, 1'b1, 10 * BIT_CYC);
    tick(IDLE_CYC);
    chk("t1_early", {31'd0, m_valid}, 0);
    tick(1);
    chk("t1_valid", {31'd0, m_valid}, 1);
    chk("t1_data", {24'd0, m_data}, 32'hB5);
    chk("t1_last", {31'd0, m_last}, 1);
    model_gap(IDLE_CYC + 1);
    drain(1'b0, popped);

    // 2: back-to-back burst
    frame(8'h11, 1'b1, 40);
    frame(8'h22, 1'b1, 40);
    frame(8'h33, 1'b1, 40);
    idle(IDLE_CYC + 20);
    drain(1'b0, popped);
    chk("t2_count", popped, 3);
    chk("t2_ovf", {31'd0, ovf}, 0);
    chk("t2_err", {24'd0, err_cnt}, err_m);

    // 3: bad frame dropped and counted
    frame(8'hAA, 1'b0, 40);
    frame(8'h55, 1'b1, 40);
    idle(IDLE_CYC + 20);
    chk("t3_err", {24'd0, err_cnt}, err_m);
    drain(1'b1, popped);
    chk("t3_count", popped, 1);

    // 4: overflow with consumer stalled, then clr and ordered drain
    for (int i = 0; i < 18; i++) frame(8'(i), 1'b1, 8);
    idle(IDLE_CYC + 20);
    chk("t4_ovf", {31'd0, ovf}, {31'd0, ovf_m});
    chk("t4_valid", {31'd0, m_valid}, 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    ovf_m = 1'b0;
    chk("t4_ovf_clr", {31'd0, ovf}, 0);
    drain(1'b0, popped);
    chk("t4_count", popped, DEPTH);

    // 5: disable while a frame is in flight
    rxBusy = 1'b1;
    tick(3 * BIT_CYC);
    enable = 1'b0;
    tick(7 * BIT_CYC);
    rxBusy = 1'b0; rx_data = 8'h5A; right = 1'b1; rxDone = 1'b1;
    tick(1);
    rxDone = 1'b0;
    model_good(8'h5A);
    model_flush();
    chk("t5_rxEn_store", {31'd0, rxEn}, 1);
    tick(1);
    chk("t5_rxEn_flush", {31'd0, rxEn}, 0);
    tick(1);
    chk("t5_valid", {31'd0, m_valid}, 1);
    chk("t5_data", {24'd0, m_data}, 32'h5A);
    chk("t5_last", {31'd0, m_last}, 1);
    tick(5);
    chk("t5_rxEn_off", {31'd0, rxEn}, 0);
    drain(1'b0, popped);

    // 6: reset mid-frame with bytes queued
    enable = 1'b1;
    tick(2);
    for (int i = 0; i < 5; i++) frame(8'($urandom_range(0, 255)), 1'b1, 8);
    rxBusy = 1'b1;
    tick(100);
    chk("t6_queued", {31'd0, m_valid}, 1);
    rst_n = 1'b0;
    tick(3);
    chk("t6_rxEn", {31'd0, rxEn}, 0);
    chk("t6_valid", {31'd0, m_valid}, 0);
    chk("t6_data", {24'd0, m_data}, 0);
    chk("t6_last", {31'd0, m_last}, 0);
    chk("t6_ovf", {31'd0, ovf}, 0);
    chk("t6_err", {24'd0, err_cnt}, 0);
    rxBusy = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    pend_v = 1'b0; err_m = 0; ovf_m = 1'b0;
    tick(2);
    chk("t6_rearm", {31'd0, rxEn}, 1);
    frame(8'h3C, 1'b1, 30);
    idle(IDLE_CYC + 20);
    drain(1'b0, popped);
    chk("t6_count", popped, 1);

    // 7: random bytes, errors and gaps; at most one long gap inside the run
    big_used = 1'b0;
    for (int i = 0; i < 10; i++) begin
      frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), $urandom_range(5, 60));
      if (!big_used && $urandom_range(0, 4) == 0) begin
        gap = IDLE_CYC + 100;
        big_used = 1'b1;
      end else begin
        gap = $urandom_range(0, 200);
      end
      idle(gap);
    end
    idle(IDLE_CYC + 50);
    chk("t7_err", {24'd0, err_cnt}, err_m);
    drain(1'b1, popped);
    chk("t7_ovf", {31'd0, ovf}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
